// File: rtl/scurve_test_control.sv
// -----------------------------------------------------------------------------
// scurve_test_control
//
// Purpose:
//   Sequencer for Microroc S-curve threshold scans. For every channel and DAC
//   step it loads the slow-control parameters, runs one S-curve point and then
//   drains the point's result FIFO into the USB data FIFO.
//
// Ports:
//   Clk, reset                 system clock, synchronous active-high reset
//   Test_Start                 start pulse (accepted only in IDLE)
//   Single_Or_64Chn            1 = scan SingleTest_Chn only, 0 = channels 0..63
//   SingleTest_Chn             channel used in single-channel mode
//   Microroc_CTest_Chn_Out     one-hot CTest enable of the channel under test
//   Microroc_10bit_DAC_Out     current threshold DAC code
//   SC_Param_Load              pulse: load slow-control parameters
//   Microroc_Config_Done       slow-control load finished
//   Single_Test_Start          pulse: start one S-curve point
//   Single_Test_Done           S-curve point finished
//   SCurve_Data_fifo_*         result FIFO (data valid 1 cycle after rd_en)
//   usb_data_fifo_wr_*         USB FIFO write port
//   SCurve_Test_Done           pulse: whole scan finished
//
// Optional feature:
//   SCURVE_STEP_TAG_EN  when defined, every step's drain is preceded by one
//                       USB word {chn[5:0], dac[9:0]}, written even when the
//                       result FIFO is already empty.
//
// States:
//   IDLE      | waiting for Test_Start
//   LOAD      | drive channel/DAC, pulse SC_Param_Load
//   WAIT_CFG  | wait for Microroc_Config_Done
//   START     | pulse Single_Test_Start
//   WAIT_TEST | wait for Single_Test_Done
//   CHECK     | (tag write) / issue FIFO read, or step finished
//   FETCH     | FIFO read latency
//   WRITE     | forward FIFO word to USB FIFO
//   NEXT      | advance DAC, channel, or finish
//   DONE      | pulse SCurve_Test_Done, clear channel/DAC outputs
// -----------------------------------------------------------------------------
module scurve_test_control #(
  parameter logic [9:0] DAC_START = 10'd0,
  parameter logic [9:0] DAC_END   = 10'd1023,
  parameter logic [9:0] DAC_STEP  = 10'd1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Test_Start,
  input  logic        Single_Or_64Chn,
  input  logic [5:0]  SingleTest_Chn,
  output logic [63:0] Microroc_CTest_Chn_Out,
  output logic [9:0]  Microroc_10bit_DAC_Out,
  output logic        SC_Param_Load,
  input  logic        Microroc_Config_Done,
  output logic        Single_Test_Start,
  input  logic        Single_Test_Done,
  input  logic        SCurve_Data_fifo_empty,
  input  logic [15:0] SCurve_Data_fifo_din,
  output logic        SCurve_Data_fifo_rd_en,
  output logic [15:0] usb_data_fifo_wr_din,
  output logic        usb_data_fifo_wr_en,
  output logic        SCurve_Test_Done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_CFG,
    S_START,
    S_WAIT_TEST,
    S_CHECK,
    S_FETCH,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        single_mode;
  logic [5:0]  chn;
  logic [9:0]  dac;

  // 11-bit sum so the end-of-range test cannot be fooled by a 10-bit wrap
  logic [10:0] dac_sum;
  logic        step_last;
  logic        scan_last;
  logic        tag_pending;

  assign dac_sum   = {1'b0, dac} + {1'b0, DAC_STEP};
  assign step_last = (dac_sum > {1'b0, DAC_END});
  assign scan_last = single_mode || (chn == 6'd63);

`ifdef SCURVE_STEP_TAG_EN
  logic tag_done;
  assign tag_pending = ~tag_done;
`else
  assign tag_pending = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (Test_Start) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_WAIT_CFG;
      S_WAIT_CFG:  if (Microroc_Config_Done) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_TEST;
      S_WAIT_TEST: if (Single_Test_Done) state_nxt = S_CHECK;
      S_CHECK: begin
        // the tag write re-enters CHECK so the empty flag is re-evaluated
        if (tag_pending)                  state_nxt = S_CHECK;
        else if (!SCurve_Data_fifo_empty) state_nxt = S_FETCH;
        else                              state_nxt = S_NEXT;
      end
      S_FETCH:     state_nxt = S_WRITE;
      S_WRITE:     state_nxt = S_CHECK;
      S_NEXT:      state_nxt = (step_last && scan_last) ? S_DONE : S_LOAD;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so each strobe appears the
  // cycle after its state and is exactly one cycle wide.
  always_ff @(posedge Clk) begin
    if (reset) begin
      single_mode            <= 1'b0;
      chn                    <= 6'd0;
      dac                    <= 10'd0;
      Microroc_CTest_Chn_Out <= 64'd0;
      Microroc_10bit_DAC_Out <= 10'd0;
      SC_Param_Load          <= 1'b0;
      Single_Test_Start      <= 1'b0;
      SCurve_Data_fifo_rd_en <= 1'b0;
      usb_data_fifo_wr_din   <= 16'd0;
      usb_data_fifo_wr_en    <= 1'b0;
      SCurve_Test_Done       <= 1'b0;
`ifdef SCURVE_STEP_TAG_EN
      tag_done               <= 1'b0;
`endif
    end else begin
      SC_Param_Load          <= 1'b0;
      Single_Test_Start      <= 1'b0;
      SCurve_Data_fifo_rd_en <= 1'b0;
      usb_data_fifo_wr_en    <= 1'b0;
      SCurve_Test_Done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Test_Start) begin
            single_mode <= Single_Or_64Chn;
            chn         <= Single_Or_64Chn ? SingleTest_Chn : 6'd0;
            dac         <= DAC_START;
          end
        end
        S_LOAD: begin
          Microroc_CTest_Chn_Out <= 64'd1 << chn;
          Microroc_10bit_DAC_Out <= dac;
          SC_Param_Load          <= 1'b1;
`ifdef SCURVE_STEP_TAG_EN
          tag_done               <= 1'b0;
`endif
        end
        S_START: Single_Test_Start <= 1'b1;
        S_CHECK: begin
          if (tag_pending) begin
            usb_data_fifo_wr_din <= {chn, dac};
            usb_data_fifo_wr_en  <= 1'b1;
`ifdef SCURVE_STEP_TAG_EN
            tag_done             <= 1'b1;
`endif
          end else if (!SCurve_Data_fifo_empty) begin
            SCurve_Data_fifo_rd_en <= 1'b1;
          end
        end
        S_WRITE: begin
          usb_data_fifo_wr_din <= SCurve_Data_fifo_din;
          usb_data_fifo_wr_en  <= 1'b1;
        end
        S_NEXT: begin
          if (step_last) begin
            if (!scan_last) begin
              chn <= chn + 6'd1;
              dac <= DAC_START;
            end
          end else begin
            dac <= dac_sum[9:0];
          end
        end
        S_DONE: begin
          Microroc_CTest_Chn_Out <= 64'd0;
          Microroc_10bit_DAC_Out <= 10'd0;
          SCurve_Test_Done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scurve_test_control.sv
module tb_scurve_test_control;

  localparam int DAC_START = 0;
  localparam int DAC_END   = 3;
  localparam int DAC_STEP  = 1;
`ifdef SCURVE_STEP_TAG_EN
  localparam int TAGW = 1;
`else
  localparam int TAGW = 0;
`endif

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        Test_Start = 1'b0;
  logic        Single_Or_64Chn = 1'b0;
  logic [5:0]  SingleTest_Chn = 6'd0;
  logic [63:0] Microroc_CTest_Chn_Out;
  logic [9:0]  Microroc_10bit_DAC_Out;
  logic        SC_Param_Load;
  logic        Microroc_Config_Done = 1'b0;
  logic        Single_Test_Start;
  logic        Single_Test_Done = 1'b0;
  logic        SCurve_Data_fifo_empty = 1'b1;
  logic [15:0] SCurve_Data_fifo_din = 16'd0;
  logic        SCurve_Data_fifo_rd_en;
  logic [15:0] usb_data_fifo_wr_din;
  logic        usb_data_fifo_wr_en;
  logic        SCurve_Test_Done;

  scurve_test_control #(
    .DAC_START(10'(DAC_START)),
    .DAC_END  (10'(DAC_END)),
    .DAC_STEP (10'(DAC_STEP))
  ) dut (
    .Clk                    (Clk),
    .reset                  (reset),
    .Test_Start             (Test_Start),
    .Single_Or_64Chn        (Single_Or_64Chn),
    .SingleTest_Chn         (SingleTest_Chn),
    .Microroc_CTest_Chn_Out (Microroc_CTest_Chn_Out),
    .Microroc_10bit_DAC_Out (Microroc_10bit_DAC_Out),
    .SC_Param_Load          (SC_Param_Load),
    .Microroc_Config_Done   (Microroc_Config_Done),
    .Single_Test_Start      (Single_Test_Start),
    .Single_Test_Done       (Single_Test_Done),
    .SCurve_Data_fifo_empty (SCurve_Data_fifo_empty),
    .SCurve_Data_fifo_din   (SCurve_Data_fifo_din),
    .SCurve_Data_fifo_rd_en (SCurve_Data_fifo_rd_en),
    .usb_data_fifo_wr_din   (usb_data_fifo_wr_din),
    .usb_data_fifo_wr_en    (usb_data_fifo_wr_en),
    .SCurve_Test_Done       (SCurve_Test_Done)
  );

  always #12 Clk = ~Clk;

  // ---------------- stub: slow-control loader, test engine, result FIFO ----
  int          words_per_step = 0;
  bit          pat_mode = 1'b0;
  int          cfg_cnt = 0;
  int          tst_cnt = 0;
  logic [15:0] seq = 16'hA000;
  logic [15:0] fq[$];
  logic [15:0] gen_q[$];

  always @(posedge Clk) begin
    Microroc_Config_Done <= 1'b0;
    Single_Test_Done     <= 1'b0;
    if (reset) begin
      cfg_cnt <= 0;
      tst_cnt <= 0;
      fq.delete();
      SCurve_Data_fifo_empty <= 1'b1;
    end else begin
      if (SCurve_Data_fifo_rd_en && fq.size() > 0)
        SCurve_Data_fifo_din <= fq.pop_front();
      if (SC_Param_Load) cfg_cnt <= 2;
      else if (cfg_cnt != 0) begin
        cfg_cnt <= cfg_cnt - 1;
        if (cfg_cnt == 1) Microroc_Config_Done <= 1'b1;
      end
      if (Single_Test_Start) tst_cnt <= 3;
      else if (tst_cnt != 0) begin
        tst_cnt <= tst_cnt - 1;
        if (tst_cnt == 1) begin
          Single_Test_Done <= 1'b1;
          for (int k = 0; k < words_per_step; k++) begin
            if (pat_mode) begin
              fq.push_back((k == 0) ? 16'h0010 : 16'h1000);
              gen_q.push_back((k == 0) ? 16'h0010 : 16'h1000);
            end else begin
              fq.push_back(seq + 16'(k));
              gen_q.push_back(seq + 16'(k));
            end
          end
          seq <= seq + 16'(words_per_step);
        end
      end
      SCurve_Data_fifo_empty <= (fq.size() == 0);
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int t_cnt = 0;
  int n_load = 0, n_start = 0, n_rd = 0, n_wr = 0, n_done = 0;
  int m_chn = 0, m_dac = 0;
  bit m_single = 1'b1;
  int ld_chn = 0, ld_dac = 0;
  int rd_t = 0;
  int gen_idx = 0;
  int start_t = 0, first_load_t = 0;
  bit first_load_pending = 1'b0;
  bit prev_load = 1'b0, prev_start = 1'b0, prev_rd = 1'b0, prev_done = 1'b0;
`ifdef SCURVE_STEP_TAG_EN
  bit          tag_pend = 1'b0;
  logic [15:0] tag_val = 16'd0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    t_cnt++;
    if (SC_Param_Load === 1'b1) begin
      n_load++;
      if (first_load_pending) begin
        first_load_t = t_cnt;
        first_load_pending = 1'b0;
      end
      check("load_width", 64'(prev_load), 64'd0);
      check("load_ctest", Microroc_CTest_Chn_Out, 64'd1 << m_chn);
      check("load_dac", 64'(Microroc_10bit_DAC_Out), 64'(m_dac));
      ld_chn = m_chn;
      ld_dac = m_dac;
`ifdef SCURVE_STEP_TAG_EN
      tag_pend = 1'b1;
      tag_val  = {6'(m_chn), 10'(m_dac)};
`endif
      if (m_dac + DAC_STEP > DAC_END) begin
        m_dac = DAC_START;
        if (!m_single) m_chn++;
      end else begin
        m_dac = m_dac + DAC_STEP;
      end
    end
    if (Single_Test_Start === 1'b1) begin
      n_start++;
      check("start_width", 64'(prev_start), 64'd0);
      check("start_ctest_hold", Microroc_CTest_Chn_Out, 64'd1 << ld_chn);
      check("start_dac_hold", 64'(Microroc_10bit_DAC_Out), 64'(ld_dac));
    end
    if (SCurve_Data_fifo_rd_en === 1'b1) begin
      n_rd++;
      rd_t = t_cnt;
      check("rd_width", 64'(prev_rd), 64'd0);
      check("rd_not_empty", 64'(SCurve_Data_fifo_empty), 64'd0);
    end
    if (usb_data_fifo_wr_en === 1'b1) begin
      n_wr++;
      check("wr_dac_hold", 64'(Microroc_10bit_DAC_Out), 64'(ld_dac));
`ifdef SCURVE_STEP_TAG_EN
      if (tag_pend) begin
        check("wr_tag", 64'(usb_data_fifo_wr_din), 64'(tag_val));
        tag_pend = 1'b0;
      end else
`endif
      begin
        check("wr_has_source", 64'(gen_idx < gen_q.size()), 64'd1);
        if (gen_idx < gen_q.size()) begin
          check("wr_data", 64'(usb_data_fifo_wr_din), 64'(gen_q[gen_idx]));
          check("wr_latency", 64'(t_cnt - rd_t), 64'd2);
          gen_idx++;
        end
      end
    end
    if (SCurve_Test_Done === 1'b1) begin
      n_done++;
      check("done_width", 64'(prev_done), 64'd0);
      check("done_ctest_clr", Microroc_CTest_Chn_Out, 64'd0);
      check("done_dac_clr", 64'(Microroc_10bit_DAC_Out), 64'd0);
    end
    prev_load  = (SC_Param_Load === 1'b1);
    prev_start = (Single_Test_Start === 1'b1);
    prev_rd    = (SCurve_Data_fifo_rd_en === 1'b1);
    prev_done  = (SCurve_Test_Done === 1'b1);
  endtask

  task automatic start_scan(input bit single, input int chn);
    Single_Or_64Chn = single;
    SingleTest_Chn  = 6'(chn);
    m_single = single;
    m_chn    = single ? chn : 0;
    m_dac    = DAC_START;
    Test_Start = 1'b1;
    start_t = t_cnt;
    first_load_pending = 1'b1;
    tick();
    Test_Start = 1'b0;
  endtask

  task automatic run_scan(input string name, input bit single, input int chn,
                          input int words, input bit pat, input int steps, input bit poke);
    int b_load, b_rd, b_wr, b_done, i;
    b_load = n_load; b_rd = n_rd; b_wr = n_wr; b_done = n_done;
    words_per_step = words;
    pat_mode = pat;
    start_scan(single, chn);
    for (i = 0; i < 8000 && n_done == b_done; i++) begin
      if (poke && i == 20) begin
        Test_Start = 1'b1;
        Single_Or_64Chn = 1'b0;
        SingleTest_Chn = 6'd40;
      end
      tick();
      Test_Start = 1'b0;
    end
    repeat (4) tick();
    check({name, "_done"}, 64'(n_done - b_done), 64'd1);
    check({name, "_loads"}, 64'(n_load - b_load), 64'(steps));
    check({name, "_reads"}, 64'(n_rd - b_rd), 64'(steps * words));
    check({name, "_writes"}, 64'(n_wr - b_wr), 64'(steps * (words + TAGW)));
    check({name, "_latency"}, 64'(first_load_t - start_t), 64'd2);
  endtask

  initial begin
    int b_start, b_load, j;
    repeat (3) tick();
    check("rst_ctest", Microroc_CTest_Chn_Out, 64'd0);
    check("rst_misc", {33'd0, Microroc_10bit_DAC_Out, SC_Param_Load, Single_Test_Start,
                       SCurve_Data_fifo_rd_en, usb_data_fifo_wr_din, usb_data_fifo_wr_en,
                       SCurve_Test_Done}, 64'd0);
    reset = 1'b0;
    repeat (2) tick();

    run_scan("single16", 1'b1, 16, 6, 1'b0, 4, 1'b1);
    run_scan("pattern", 1'b1, 5, 2, 1'b1, 4, 1'b0);
    run_scan("empty_drain", 1'b1, 9, 0, 1'b0, 4, 1'b0);
    run_scan("all64", 1'b0, 0, 1, 1'b0, 64 * 4, 1'b0);
    check("all64_last_chn", 64'(ld_chn), 64'd63);

    // abort in WAIT_TEST, then restart from DAC_START
    words_per_step = 1;
    pat_mode = 1'b0;
    b_start = n_start;
    start_scan(1'b1, 7);
    for (j = 0; j < 100 && n_start == b_start; j++) tick();
    check("abort_reached_wait_test", 64'(n_start - b_start), 64'd1);
    reset = 1'b1;
    tick();
    check("abort_ctest", Microroc_CTest_Chn_Out, 64'd0);
    check("abort_misc", {33'd0, Microroc_10bit_DAC_Out, SC_Param_Load, Single_Test_Start,
                         SCurve_Data_fifo_rd_en, usb_data_fifo_wr_din, usb_data_fifo_wr_en,
                         SCurve_Test_Done}, 64'd0);
    reset = 1'b0;
`ifdef SCURVE_STEP_TAG_EN
    tag_pend = 1'b0;
`endif
    b_load = n_load;
    repeat (10) tick();
    check("abort_idle", 64'(n_load - b_load), 64'd0);
    run_scan("restart", 1'b1, 7, 1, 1'b0, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
